// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - recovers the period of a single-cycle pulse stream
//
// Measures the number of clock cycles between consecutive pulses on i_pulse,
// reports each measurement, tracks period stability and flags missing pulses.
//
// Ports:
//   i_clk      clock, all state updates on the rising edge
//   i_reset_n  synchronous active-low reset
//   i_pulse    event input, one event per rising edge sampled high
//   o_k        last valid measured period in cycles
//   o_valid    one-cycle strobe, o_k was just updated
//   o_locked   period has repeated LOCK_CNT times after the first measurement
//   o_timeout  one-cycle strobe, no event within 2^N-1 cycles
module pulse_period_meter #(
  parameter int N        = 3,
  parameter int LOCK_CNT = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_pulse,
  output logic [N-1:0] o_k,
  output logic         o_valid,
  output logic         o_locked,
  output logic         o_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [N-1:0] CNT_MAX  = '1;
  localparam logic [N-1:0] CNT_ONE  = N'(1);
  localparam logic [4:0]   LOCK_THR = 5'(LOCK_CNT);

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [3:0]   match_q, match_d;
  logic         have_k_q, have_k_d;
  logic [N-1:0] k_q, k_d;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         timeout_q, timeout_d;

  // One bit wider than match_q so the lock threshold compare sees the
  // unsaturated increment.
  logic [4:0]   match_inc;

  assign match_inc = {1'b0, match_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    have_k_d  = have_k_q;
    k_d       = k_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        // First event only starts the measurement window.
        if (i_pulse) begin
          cnt_d   = CNT_ONE;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // An event on the terminal count is still a valid period of 2^N-1,
        // so the event branch is checked before the timeout branch.
        if (i_pulse) begin
          k_d      = cnt_q;
          valid_d  = 1'b1;
          have_k_d = 1'b1;
          cnt_d    = CNT_ONE;
          if (have_k_q) begin
            if (cnt_q == k_q) begin
              match_d = (match_q == 4'hF) ? 4'hF : match_q + 4'd1;
              if (match_inc >= LOCK_THR) begin
                locked_d = 1'b1;
              end
            end else begin
              match_d  = 4'd0;
              locked_d = 1'b0;
            end
          end else begin
            match_d = 4'd0;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = 4'd0;
          have_k_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      match_q   <= 4'd0;
      have_k_q  <= 1'b0;
      k_q       <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      have_k_q  <= have_k_d;
      k_q       <= k_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_k       = k_q;
  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - self-checking bench for pulse_period_meter
module tb_pulse_period_meter;

  localparam int N        = 3;
  localparam int LOCK_CNT = 2;
  localparam int KMAX     = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_pulse = 1'b0;
  logic [N-1:0] o_k;
  logic         o_valid;
  logic         o_locked;
  logic         o_timeout;

  pulse_period_meter #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_pulse   (i_pulse),
    .o_k       (o_k),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: timestamps of pulses, period = difference of edge
  // indices, stability = length of the run of equal periods.
  int           cyc = 0;
  bit           active = 0;
  int           last_edge = 0;
  bit           have_k = 0;
  int           streak = 0;
  logic [N-1:0] m_k = '0;
  logic         m_valid = 1'b0;
  logic         m_locked = 1'b0;
  logic         m_timeout = 1'b0;

  always @(posedge clk) begin
    int period;
    cyc = cyc + 1;
    if (!i_reset_n) begin
      active = 0; have_k = 0; streak = 0;
      m_k = '0; m_valid = 1'b0; m_locked = 1'b0; m_timeout = 1'b0;
    end else begin
      m_valid   = 1'b0;
      m_timeout = 1'b0;
      if (i_pulse) begin
        if (active) begin
          period  = cyc - last_edge;
          m_valid = 1'b1;
          if (have_k && period == int'(m_k)) begin
            streak = streak + 1;
            if (streak >= LOCK_CNT) m_locked = 1'b1;
          end else begin
            if (have_k) m_locked = 1'b0;
            streak = 0;
          end
          m_k    = N'(period);
          have_k = 1;
        end
        active    = 1;
        last_edge = cyc;
      end else if (active && (cyc - last_edge) == KMAX) begin
        m_timeout = 1'b1;
        m_locked  = 1'b0;
        active    = 0;
        have_k    = 0;
        streak    = 0;
      end
    end
  end

  // Hand-computed pins, written only by the stimulus process.
  int           pin_cyc = -1;
  logic [N-1:0] pin_k;
  logic         pin_v, pin_l, pin_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("k",       8'(o_k),       8'(m_k));
      chk("valid",   8'(o_valid),   8'(m_valid));
      chk("locked",  8'(o_locked),  8'(m_locked));
      chk("timeout", 8'(o_timeout), 8'(m_timeout));
      if (pin_cyc == cyc) begin
        chk("pin_k",       8'(o_k),       8'(pin_k));
        chk("pin_valid",   8'(o_valid),   8'(pin_v));
        chk("pin_locked",  8'(o_locked),  8'(pin_l));
        chk("pin_timeout", 8'(o_timeout), 8'(pin_t));
      end
    end
  end

  task automatic tick(input logic p, input logic r);
    i_pulse   = p;
    i_reset_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic gap_pulse(input int k);
    for (int i = 0; i < k - 1; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
  endtask

  task automatic pin(input logic [N-1:0] k, input logic v, input logic l, input logic t);
    pin_cyc = cyc;
    pin_k   = k;
    pin_v   = v;
    pin_l   = l;
    pin_t   = t;
  endtask

  initial begin
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    pin(3'd0, 1'b0, 1'b0, 1'b0);

    // k=4 stream: pulses at edges 4, 8, 12, 16 after release
    gap_pulse(4); pin(3'd0, 1'b0, 1'b0, 1'b0);
    gap_pulse(4); pin(3'd4, 1'b1, 1'b0, 1'b0);
    gap_pulse(4); pin(3'd4, 1'b1, 1'b0, 1'b0);
    gap_pulse(4); pin(3'd4, 1'b1, 1'b1, 1'b0);

    // period change to 6
    gap_pulse(6); pin(3'd6, 1'b1, 1'b0, 1'b0);
    gap_pulse(6); pin(3'd6, 1'b1, 1'b0, 1'b0);
    gap_pulse(6); pin(3'd6, 1'b1, 1'b1, 1'b0);

    // lock on k=3, then stop pulsing
    gap_pulse(3); pin(3'd3, 1'b1, 1'b0, 1'b0);
    gap_pulse(3); pin(3'd3, 1'b1, 1'b0, 1'b0);
    gap_pulse(3); pin(3'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    pin(3'd3, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1); pin(3'd3, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1); pin(3'd3, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1); pin(3'd3, 1'b0, 1'b0, 1'b0);

    // maximum period 7: valid, never a timeout
    gap_pulse(7); pin(3'd7, 1'b1, 1'b0, 1'b0);
    gap_pulse(7); pin(3'd7, 1'b1, 1'b0, 1'b0);
    gap_pulse(7); pin(3'd7, 1'b1, 1'b1, 1'b0);

    // period 8: timeout every time, each pulse restarts
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
      pin(3'd7, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1); pin(3'd7, 1'b0, 1'b0, 1'b0);
    end

    // continuous pulse from a clean start
    tick(1'b0, 1'b0); pin(3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1); pin(3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1); pin(3'd1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1); pin(3'd1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1); pin(3'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
    pin(3'd1, 1'b1, 1'b1, 1'b0);

    // lock on k=4, then reset mid-operation
    gap_pulse(4); pin(3'd4, 1'b1, 1'b0, 1'b0);
    gap_pulse(4); pin(3'd4, 1'b1, 1'b0, 1'b0);
    gap_pulse(4); pin(3'd4, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0); pin(3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1); pin(3'd0, 1'b0, 1'b0, 1'b0);
    gap_pulse(4); pin(3'd4, 1'b1, 1'b0, 1'b0);

    // pseudo-random tail checked against the model only
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    tick(1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
